// File: rtl/demux4_dispatch_if.sv
// rtl/demux4_dispatch_if.sv - handshake bundle between an upstream source, the dispatcher and four channels
// Signals:
//   in_valid/in_ready/in_data : upstream item handshake and payload
//   enable                    : per-channel dispatch enable mask
//   out_valid/out_ready       : one-hot channel valid and per-channel ready
//   out_data                  : held payload, shared by all channels
//   sel                       : index of the channel currently targeted
//   xfer_count                : count of completed output transfers
// Modports: master = environment side (drives inputs), slave = dispatcher side.
interface demux4_dispatch_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [3:0]        enable;
   logic [3:0]        out_valid;
   logic [3:0]        out_ready;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        sel;
   logic [15:0]       xfer_count;

   modport master (
      output in_valid, in_data, enable, out_ready,
      input  in_ready, out_valid, out_data, sel, xfer_count
   );

   modport slave (
      input  in_valid, in_data, enable, out_ready,
      output in_ready, out_valid, out_data, sel, xfer_count
   );
endinterface

// File: rtl/demux4_dispatch.sv
// rtl/demux4_dispatch.sv - one-deep round-robin dispatcher from one stream to four channels
// Ports:
//   clk : single clock, rising edge
//   rst : asynchronous active-high reset
//   bus : demux4_dispatch_if.slave (upstream handshake, enable mask, channel handshake,
//         shared payload, target select, transfer counter)
module demux4_dispatch #(
   parameter int DATA_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   demux4_dispatch_if.slave   bus
);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [1:0]        sel_q, sel_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [15:0]       count_q, count_d;

   logic any_en;
   logic in_ready_c;
   logic accept;
   logic xfer;

   // First enabled channel at or after p (mod 4). Returns p when no channel is enabled;
   // callers never act on that value because in_ready is low with an empty mask.
   function automatic logic [1:0] pick(input logic [1:0] p, input logic [3:0] en);
      logic [1:0] c;
      pick = p;
      // Scan farthest offset first so the nearest enabled channel is written last.
      for (int k = 3; k >= 0; k--) begin
         c = p + 2'(k);
         if (en[c]) pick = c;
      end
   endfunction

   assign any_en     = |bus.enable;
   // In HOLD the slot frees up in the same cycle the held item leaves, so a new item
   // may be taken alongside the transfer.
   assign in_ready_c = any_en && ((state_q == IDLE) || bus.out_ready[sel_q]);
   assign accept     = bus.in_valid && in_ready_c;
   assign xfer       = (state_q == HOLD) && bus.out_ready[sel_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         sel_q   <= 2'd0;
         hold_q  <= '0;
         count_q <= 16'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         hold_q  <= hold_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      hold_d  = hold_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               hold_d  = bus.in_data;
               sel_d   = pick(ptr_q, bus.enable);
               state_d = HOLD;
            end
         end
         HOLD: begin
            // sel is frozen until the held item leaves; enable changes only steer the next item.
            if (xfer) begin
               ptr_d   = sel_q + 2'd1;
               count_d = count_q + 16'd1;
               if (accept) begin
                  hold_d = bus.in_data;
                  sel_d  = pick(sel_q + 2'd1, bus.enable);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode straight from registers so reset clears out_valid without a clock.
   assign bus.in_ready   = in_ready_c;
   assign bus.out_valid  = (state_q == HOLD) ? (4'b0001 << sel_q) : 4'b0000;
   assign bus.out_data   = hold_q;
   assign bus.sel        = sel_q;
   assign bus.xfer_count = count_q;

endmodule

// File: tb/tb_demux4_dispatch.sv
// tb/tb_demux4_dispatch.sv - scoreboard bench for demux4_dispatch
module tb_demux4_dispatch;

   logic clk;
   logic rst;

   demux4_dispatch_if #(.DATA_W(8)) bus ();

   demux4_dispatch #(.DATA_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;
   logic [9:0]  sb[$];        // {channel, data}
   logic [3:0]  forbid = 4'b0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic iv, input logic [7:0] d);
      bus.in_valid = iv;
      bus.in_data  = d;
      #1;
   endtask

   // Monitor outputs at the sample point, record an accepted item, then advance one cycle.
   task automatic step(input logic [1:0] ch);
      logic [9:0] e;
      if (bus.out_valid !== 4'b0000) begin
         chk("ov_onehot", 32'($onehot(bus.out_valid)), 32'd1);
         if (forbid != 4'b0000) chk("ov_forbidden", 32'(bus.out_valid & forbid), 32'd0);
         if ((bus.out_valid & bus.out_ready) != 4'b0000) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("xfer_sel", 32'(bus.sel), 32'(e[9:8]));
               chk("xfer_ov", 32'(bus.out_valid), 32'(4'b0001 << e[9:8]));
               chk("xfer_data", 32'(bus.out_data), 32'(e[7:0]));
            end
         end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back({ch, bus.in_data});
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [3:0] ov_seq [6];

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.enable    = 4'b0000;
      bus.out_ready = 4'b0000;
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_sel", 32'(bus.sel), 32'd0);
      chk("rst_count", 32'(bus.xfer_count), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      bus.enable = 4'b1111;
      #1;
      chk("rst_in_ready_en", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Back-to-back on all channels: A,B,C,D -> 0,1,2,3.
      bus.out_ready = 4'b1111;
      ov_seq = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
      for (int i = 0; i < 6; i++) begin
         drv(i < 4, 8'hA0 + 8'(i));
         chk("rr_ov", 32'(bus.out_valid), 32'(ov_seq[i]));
         if (i < 4) chk("rr_in_ready", 32'(bus.in_ready), 32'd1);
         step(2'(i));
      end
      chk("rr_count", 32'(bus.xfer_count), 32'd4);

      // Sparse mask 1010: channels 1,3,1, never 0 or 2.
      bus.enable = 4'b1010;
      forbid     = 4'b0101;
      drv(1'b1, 8'hE1); step(2'd1);
      drv(1'b1, 8'hE2); step(2'd3);
      drv(1'b1, 8'hE3); step(2'd1);
      drv(1'b0, 8'h00); step(2'd0);
      drv(1'b0, 8'h00);
      chk("sparse_idle_ov", 32'(bus.out_valid), 32'd0);
      step(2'd0);
      forbid = 4'b0000;
      chk("sparse_count", 32'(bus.xfer_count), 32'd7);

      // Empty mask blocks intake; enabling channel 2 lets the item through.
      bus.enable = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         drv(1'b1, 8'h5C);
         chk("mask0_in_ready", 32'(bus.in_ready), 32'd0);
         chk("mask0_ov", 32'(bus.out_valid), 32'd0);
         step(2'd0);
      end
      bus.enable = 4'b0100;
      drv(1'b1, 8'h5C);
      chk("mask4_in_ready", 32'(bus.in_ready), 32'd1);
      step(2'd2);
      drv(1'b0, 8'h00);
      chk("mask4_ov", 32'(bus.out_valid), 32'b0100);
      step(2'd0);

      // Held item on channel 1 is not retargeted by an enable change or a foreign ready.
      bus.enable    = 4'b0010;
      bus.out_ready = 4'b0000;
      drv(1'b1, 8'h3B);
      step(2'd1);
      bus.enable    = 4'b0001;
      bus.out_ready = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         drv(1'b0, 8'h00);
         chk("stall_ov", 32'(bus.out_valid), 32'b0010);
         chk("stall_sel", 32'(bus.sel), 32'd1);
         chk("stall_data", 32'(bus.out_data), 32'h3B);
         chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
         step(2'd0);
      end
      bus.out_ready = 4'b0010;
      drv(1'b0, 8'h00);
      step(2'd0);
      drv(1'b0, 8'h00);
      chk("stall_done_ov", 32'(bus.out_valid), 32'd0);
      chk("stall_done_data", 32'(bus.out_data), 32'h3B);
      chk("stall_count", 32'(bus.xfer_count), 32'd9);

      // Reset mid-HOLD drops the item at once; the next item restarts on channel 0.
      bus.enable    = 4'b1111;
      bus.out_ready = 4'b0000;
      drv(1'b1, 8'h77);
      step(2'd2);
      drv(1'b0, 8'h00);
      chk("hold_ov", 32'(bus.out_valid), 32'b0100);
      rst = 1'b1;
      #1;
      chk("arst_ov", 32'(bus.out_valid), 32'd0);
      chk("arst_count", 32'(bus.xfer_count), 32'd0);
      chk("arst_sel", 32'(bus.sel), 32'd0);
      chk("arst_data", 32'(bus.out_data), 32'd0);
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 4'b1111;
      drv(1'b1, 8'h88); step(2'd0);
      drv(1'b0, 8'h00); step(2'd0);
      chk("post_rst_count", 32'(bus.xfer_count), 32'd1);

      // 65536 sustained transfers wrap the counter.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 65536; i++) begin
         drv(1'b1, 8'(i));
         step(2'(i));
      end
      chk("wrap_ffff", 32'(bus.xfer_count), 32'hFFFF);
      drv(1'b0, 8'h00);
      step(2'd0);
      chk("wrap_zero", 32'(bus.xfer_count), 32'h0000);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/demux4_dispatch.md
DEMUX4_DISPATCH -- requirements
Module: demux4_dispatch

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the payload width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, upstream item present.
REQ-005 SHALL have port in_ready, output, 1, dispatcher accepts the item this cycle.
REQ-006 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-007 SHALL have port enable, input, 4, per-channel dispatch enable mask.
REQ-008 SHALL have port out_valid, output, 4, one-hot valid toward channel 0..3.
REQ-009 SHALL have port out_ready, input, 4, per-channel downstream ready.
REQ-010 SHALL have port out_data, output, DATA_W, held payload, shared by all channels.
REQ-011 SHALL have port sel, output, 2, index of the channel currently targeted; drives a demux select.
REQ-012 SHALL have port xfer_count, output, 16, count of completed output transfers.

Function
REQ-013 SHALL implement two states, IDLE (holding register empty) and HOLD (one item held).
REQ-014 SHALL keep a 2-bit round-robin pointer ptr naming the first channel to consider.
REQ-015 SHALL define pick(p) as the first channel c in order p, p+1, ... mod 4 with enable[c]=1; pick is undefined when enable=0000.
REQ-016 SHALL assert in_ready in IDLE when enable!=0000, and in HOLD when out_ready[sel]=1 and enable!=0000; otherwise in_ready=0.
REQ-017 SHALL, on an accept (in_valid and in_ready) in IDLE, load in_data into the holding register, set sel=pick(ptr), and enter HOLD the next cycle.
REQ-018 SHALL, in HOLD, drive out_valid as one-hot at sel and out_data from the holding register; in IDLE out_valid=0000.
REQ-019 SHALL complete a transfer when in HOLD and out_ready[sel]=1; then ptr<=sel+1 mod 4 and xfer_count increments by 1.
REQ-020 SHALL, on a transfer with a simultaneous accept, load the new item, set sel=pick(sel+1 mod 4), and stay in HOLD (one item per cycle sustained throughput).
REQ-021 SHALL, on a transfer without an accept, return to IDLE.
REQ-022 SHALL hold sel, out_valid and out_data stable in HOLD until the transfer; a change of enable while in HOLD SHALL NOT retarget or retract the held item.
REQ-023 SHALL ignore out_ready bits other than out_ready[sel].
REQ-024 SHALL wrap xfer_count from 0xFFFF to 0x0000.
REQ-025 SHALL leave out_data equal to the last loaded value in IDLE.

Reset
REQ-026 SHALL, while rst=1, immediately force state=IDLE, ptr=0, sel=0, out_valid=0000, xfer_count=0, and holding register=0, with in_ready then following REQ-016.
REQ-027 SHALL discard any held item when rst asserts mid-operation, with no transfer counted.

Verification
REQ-028 SHALL cover enable=1111, out_ready=1111, four back-to-back items A,B,C,D -> delivered on channels 0,1,2,3 in consecutive cycles, xfer_count=4.
REQ-029 SHALL cover enable=1010, three items -> channels 1,3,1; out_valid never asserted on channels 0 or 2.
REQ-030 SHALL cover enable=0000 with in_valid=1 -> in_ready=0, out_valid=0000, then enable=0100 -> item accepted and delivered on channel 2.
REQ-031 SHALL cover item held on channel 1 with out_ready[1]=0 for 5 cycles while out_ready[0]=1 and enable is switched to 0001 -> out_valid=0010 and out_data stable throughout; transfer occurs on out_ready[1]=1.
REQ-032 SHALL cover rst pulsed while in HOLD -> out_valid=0000 immediately, xfer_count=0, next item goes to channel 0.
REQ-033 SHALL cover 65536 transfers -> xfer_count wraps to 0x0000.
